system_id_checker: RTL and testbench
====================================

SYSTEM_ID_CHECKER -- requirements
Module: system_id_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 0, 32-bit system ID value required at slave word address 0.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 1561603805, 32-bit build timestamp value required at slave word address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, range 1..255; the maximum number of consecutive waitrequest-high cycles tolerated per read.
REQ-004 clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to run one check sequence.
REQ-007 address  output  1  Avalon-MM master word address: 0 = ID, 1 = timestamp.
REQ-008 read  output  1  Avalon-MM master read strobe.
REQ-009 waitrequest  input  1  slave stall; a read completes in a cycle where read=1 and waitrequest=0.
REQ-010 readdata  input  32  slave read data, sampled in the completing cycle.
REQ-011 busy  output  1  high from the cycle after start is accepted until done.
REQ-012 done  output  1  one-cycle pulse ending a sequence.
REQ-013 pass  output  1  valid with done and held until the next accepted start; 1 = status OK.
REQ-014 status  output  2  00 OK, 01 ID mismatch, 10 timestamp mismatch, 11 timeout; held like pass.
REQ-015 id_value, ts_value  output  32 each  last captured ID and timestamp words.

Function
REQ-016 The states SHALL be IDLE, RD_ID, RD_TS and FINISH.
REQ-017 IDLE: start=1 -> RD_ID next cycle; start SHALL be ignored in every other state.
REQ-018 RD_ID: read=1, address=0; on waitrequest=0, readdata -> id_value, go to RD_TS.
REQ-019 RD_TS: read=1, address=1; on waitrequest=0, readdata -> ts_value, go to FINISH.
REQ-020 read SHALL be held high with a stable address until completion or timeout; read SHALL NOT drop while waitrequest=1 except on timeout.
REQ-021 With a zero-wait slave, start at cycle N SHALL give read high in cycles N+1 and N+2 and done at cycle N+3.
REQ-022 A per-read stall counter SHALL clear on entry to RD_ID and RD_TS and increment each cycle with read=1 and waitrequest=1.
REQ-023 If the counter reaches TIMEOUT_CYCLES, read SHALL deassert the next cycle, the state SHALL go to FINISH, status=11, and the uncaptured value register SHALL keep its previous contents.
REQ-024 FINISH: done=1 for exactly one cycle, then IDLE; read=0 throughout.
REQ-025 Status priority SHALL be timeout > ID mismatch > timestamp mismatch > OK; comparison uses all 32 bits.
REQ-026 pass SHALL equal (status == 00), and both SHALL update only in the FINISH cycle.
REQ-027 A start coincident with done SHALL be ignored; a new start is accepted only in IDLE.

Reset
REQ-028 Reset SHALL force IDLE and set read=0, address=0, busy=0, done=0, pass=0, status=00, id_value=0, ts_value=0, and stall counter=0.
REQ-029 Reset asserted mid-read SHALL drop read asynchronously; no done pulse follows reset.

Structure
REQ-030 The shared package system_id_checker_pkg SHALL hold the state enum, the 2-bit status codes, and the address constants ADDR_ID=0 and ADDR_TS=1.
REQ-031 The stall counter SHALL be the sub-module system_id_checker_timeout, with inputs clear and count and output expired.

Verification
REQ-032 Zero-wait slave returning 0 and 1561603805, start pulse -> read in 2 cycles, done 3 cycles after start, pass=1, status=00, ts_value=1561603805.
REQ-033 Slave returning ID=0x00000001 and the correct timestamp -> status=01, pass=0, id_value=0x00000001.
REQ-034 Both words wrong -> status=01, showing ID mismatch priority over timestamp mismatch.
REQ-035 waitrequest stuck high on address 1 with TIMEOUT_CYCLES=16 -> read drops after 16 stall cycles, status=11, ts_value unchanged, one done pulse.
REQ-036 waitrequest high for 3 cycles on each read -> address and read stay stable through the stalls, done 9 cycles after start, pass=1.
REQ-037 Reset asserted during an RD_TS stall -> read=0 immediately, all outputs at reset values, no done; a later start runs a clean sequence.

Source files
------------

// File: rtl/system_id_checker_pkg.sv
// Shared definitions for the system ID checker: FSM state codes, result
// codes, slave word addresses and the result-priority helper.
package system_id_checker_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RD_ID  = 2'd1;
    localparam logic [1:0] ST_RD_TS  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'b00,
        STATUS_ID_ERR  = 2'b01,
        STATUS_TS_ERR  = 2'b10,
        STATUS_TIMEOUT = 2'b11
    } status_e;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // A timeout outranks either mismatch, and an ID mismatch outranks a timestamp one.
    function automatic status_e resolve_status(input logic timeout,
                                               input logic id_bad,
                                               input logic ts_bad);
        if (timeout)
            return STATUS_TIMEOUT;
        if (id_bad)
            return STATUS_ID_ERR;
        if (ts_bad)
            return STATUS_TS_ERR;
        return STATUS_OK;
    endfunction

endpackage

// File: rtl/system_id_checker_if.sv
// Avalon-MM read-only bus between the checker (master) and the ID/timestamp slave.
interface system_id_checker_if;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata
    );
endinterface

// File: rtl/system_id_checker_timeout.sv
// Per-read stall counter; o_expired flags the stall cycle that uses up the budget,
// so the caller can leave the read state on that same edge.
module system_id_checker_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    logic [7:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_count) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = i_count && (r_count >= 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/system_id_checker.sv
// Reads the system ID and build timestamp words from an Avalon-MM slave,
// compares both against the expected values and reports a 2-bit result.
module system_id_checker
    import system_id_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1561603805,
    parameter int unsigned TIMEOUT_CYCLES     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    system_id_checker_if.master  m_bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [1:0]           o_status,
    output logic [31:0]          o_id_value,
    output logic [31:0]          o_ts_value
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_id;
    logic [31:0] r_ts;
    status_e     r_status;
    logic        r_pass;

    logic        w_reading;
    logic        w_accept;
    logic        w_stall;
    logic        w_expired;
    logic        w_clear;
    logic        w_finish_entry;
    status_e     w_status_next;

    assign w_reading = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
    assign w_accept  = w_reading && !m_bus.waitrequest;
    assign w_stall   = w_reading && m_bus.waitrequest;
    // Clearing on every completed read gives the timestamp read a fresh budget.
    assign w_clear   = !w_reading || w_accept;

    system_id_checker_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_clear),
        .i_count   (w_stall),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start)
                    w_state_next = ST_RD_ID;
            end
            ST_RD_ID: begin
                if (w_accept)
                    w_state_next = ST_RD_TS;
                else if (w_expired)
                    w_state_next = ST_FINISH;
            end
            ST_RD_TS: begin
                if (w_accept || w_expired)
                    w_state_next = ST_FINISH;
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_finish_entry = ((r_state == ST_RD_ID) && w_expired) ||
                            ((r_state == ST_RD_TS) && (w_accept || w_expired));

    // Only evaluated on the edge into FINISH; the timestamp is compared straight off the bus.
    assign w_status_next = resolve_status(w_expired,
                                          r_id != EXPECTED_ID,
                                          m_bus.readdata != EXPECTED_TIMESTAMP);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_id     <= 32'd0;
            r_ts     <= 32'd0;
            r_status <= STATUS_OK;
            r_pass   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_RD_ID) && w_accept)
                r_id <= m_bus.readdata;
            if ((r_state == ST_RD_TS) && w_accept)
                r_ts <= m_bus.readdata;
            if (w_finish_entry) begin
                r_status <= w_status_next;
                r_pass   <= (w_status_next == STATUS_OK);
            end
        end
    end

    assign m_bus.read    = w_reading;
    assign m_bus.address = (r_state == ST_RD_TS) ? ADDR_TS : ADDR_ID;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_FINISH);
    assign o_pass        = r_pass;
    assign o_status      = r_status;
    assign o_id_value    = r_id;
    assign o_ts_value    = r_ts;

endmodule

// File: tb/tb_system_id_checker.sv
// Randomized self-checking bench for system_id_checker; a transaction-level
// model predicts read lengths, done timing, result code and captured words.
module tb_system_id_checker;
    import system_id_checker_pkg::*;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1561603805;
    localparam int          T      = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [1:0]  status;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_txn    = 0;
    logic [31:0] m_id     = 32'd0;
    logic [31:0] m_ts     = 32'd0;

    system_id_checker_if bus_if ();

    always #5 clk = ~clk;

    system_id_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (T)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .m_bus      (bus_if),
        .o_busy     (busy),
        .o_done     (done),
        .o_pass     (pass),
        .o_status   (status),
        .o_id_value (id_value),
        .o_ts_value (ts_value)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    // sid/sts = stall cycles the slave inserts before answering each read (>= T never answers).
    task automatic run_txn(input logic [31:0] id_w, input logic [31:0] ts_w,
                           input int sid, input int sts, input bit poke_start);
        int         len_id, len_ts, exp_done, done_cyc, rd0, rd1;
        bit         to_id, to_ts, prev_stall, addr_slip, busy_drop;
        logic       prev_addr;
        logic [1:0] exp_st;

        to_id    = (sid >= T);
        to_ts    = !to_id && (sts >= T);
        len_id   = to_id ? T : sid + 1;
        len_ts   = to_id ? 0 : (to_ts ? T : sts + 1);
        exp_done = 1 + len_id + len_ts;
        if (to_id || to_ts)   exp_st = 2'b11;
        else if (id_w != EXP_ID) exp_st = 2'b01;
        else if (ts_w != EXP_TS) exp_st = 2'b10;
        else                  exp_st = 2'b00;
        if (!to_id)           m_id = id_w;
        if (!to_id && !to_ts) m_ts = ts_w;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        rd0 = 0; rd1 = 0; done_cyc = -1;
        prev_stall = 1'b0; prev_addr = 1'b0; addr_slip = 1'b0; busy_drop = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (cyc > 1) @(negedge clk);
            start = (poke_start && cyc == 2);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (!busy) busy_drop = 1'b1;
            if (bus_if.read) begin
                if (prev_stall && bus_if.address != prev_addr) addr_slip = 1'b1;
                if (bus_if.address == 1'b0) begin
                    bus_if.waitrequest = (rd0 < sid);
                    bus_if.readdata    = bus_if.waitrequest ? $urandom : id_w;
                    rd0++;
                end else begin
                    bus_if.waitrequest = (rd1 < sts);
                    bus_if.readdata    = bus_if.waitrequest ? $urandom : ts_w;
                    rd1++;
                end
                prev_stall = bus_if.waitrequest;
                prev_addr  = bus_if.address;
            end else begin
                prev_stall         = 1'b0;
                bus_if.waitrequest = 1'($urandom_range(0, 1));
            end
        end
        check("done_cycle", done_cyc, exp_done);
        check("id_reads", rd0, len_id);
        check("ts_reads", rd1, len_ts);
        check("addr_stable", {31'd0, addr_slip}, 32'd0);
        check("busy_held", {31'd0, busy_drop}, 32'd0);
        check("status", {30'd0, status}, {30'd0, exp_st});
        check("pass", {31'd0, pass}, {31'd0, exp_st == 2'b00});
        check("id_value", id_value, m_id);
        check("ts_value", ts_value, m_ts);
        // Start coincident with done must not launch a new sequence.
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd0);
        check("idle_read", {31'd0, bus_if.read}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("status_hold", {30'd0, status}, {30'd0, exp_st});
        n_txn++;
        $display("txn %0d: id=0x%08h ts=0x%08h sid=%0d sts=%0d done@%0d status=%0d",
                 n_txn, id_w, ts_w, sid, sts, done_cyc, status);
    endtask

    task automatic reset_mid_read();
        int rd1;
        bit reached, saw_done;
        rd1 = 0; reached = 1'b0; saw_done = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 1; cyc <= 40 && !reached; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (bus_if.read && bus_if.address == 1'b1) begin
                bus_if.waitrequest = 1'b1;
                rd1++;
                if (rd1 == 3) reached = 1'b1;
            end else begin
                bus_if.waitrequest = 1'b0;
                bus_if.readdata    = 32'h1234_5678;
            end
        end
        check("rst_reached_ts", {31'd0, reached}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_read", {31'd0, bus_if.read}, 32'd0);
        check("rst_addr", {31'd0, bus_if.address}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_status", {30'd0, status}, 32'd0);
        check("rst_id", id_value, 32'd0);
        check("rst_ts", ts_value, 32'd0);
        @(negedge clk); rst = 1'b0;
        bus_if.waitrequest = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (done || bus_if.read) saw_done = 1'b1;
        end
        check("rst_no_done", {31'd0, saw_done}, 32'd0);
        m_id = 32'd0;
        m_ts = 32'd0;
        $display("txn reset: asserted during timestamp stall");
    endtask

    initial begin
        logic [31:0] id_w, ts_w;
        int          sid, sts;
        rst = 1'b1; start = 1'b0;
        bus_if.waitrequest = 1'b0;
        bus_if.readdata    = 32'd0;
        repeat (3) @(negedge clk);
        check("init_read", {31'd0, bus_if.read}, 32'd0);
        check("init_busy", {31'd0, busy}, 32'd0);
        check("init_done", {31'd0, done}, 32'd0);
        check("init_pass", {31'd0, pass}, 32'd0);
        check("init_status", {30'd0, status}, 32'd0);
        check("init_id", id_value, 32'd0);
        check("init_ts", ts_value, 32'd0);
        rst = 1'b0;

        run_txn(EXP_ID, EXP_TS, 0, 0, 1'b0);
        run_txn(32'h0000_0001, EXP_TS, 0, 0, 1'b0);
        run_txn(32'h0000_0005, 32'h0000_0007, 0, 0, 1'b0);
        run_txn(EXP_ID, EXP_TS, 0, 100, 1'b0);
        run_txn(EXP_ID, EXP_TS, 3, 3, 1'b1);
        run_txn(EXP_ID, EXP_TS, T - 1, T - 1, 1'b0);
        run_txn(EXP_ID, EXP_TS, T, 0, 1'b0);
        reset_mid_read();
        run_txn(EXP_ID, EXP_TS, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            id_w = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
            ts_w = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
            case ($urandom_range(0, 9))
                0:       sid = T;
                1:       sid = T - 1;
                default: sid = int'($urandom_range(0, 4));
            endcase
            case ($urandom_range(0, 9))
                0:       sts = T + int'($urandom_range(0, 3));
                1:       sts = T - 1;
                default: sts = int'($urandom_range(0, 4));
            endcase
            run_txn(id_w, ts_w, sid, sts, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
